siso_8_bit: RTL and testbench
=============================

Name: siso_8_bit

Overview:
- Serial-in serial-out shift register: one data bit enters per clock, and each bit leaves unchanged DEPTH (default 8) clocks later.
- Used as a fixed digital delay line / bit-stream skew element between serial producers and consumers.
- Single clock domain; no parallel access.

Parameters:
- DEPTH, 8, number of register stages (delay in clock cycles); legal range 2..64; default build is 8.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous active-low reset; clears every stage.
- serial_in  input  1  serial data bit, sampled on each rising clk edge while rst_n=1.
- serial_out  output  1  last stage of the chain (stage[DEPTH-1]); driven directly from a flop, no combinational path from serial_in.

Behaviour:
- State: stage[0..DEPTH-1], 1 bit each, all flops with async active-low clear.
- Reset:
  - rst_n=0 immediately (no clock needed) forces all stages to 0, so serial_out=0.
  - While rst_n stays 0, clk edges have no effect and serial_in is ignored.
- Shift: on each rising clk with rst_n=1, stage[0]<=serial_in and stage[i]<=stage[i-1] for i=1..DEPTH-1, simultaneously (non-blocking).
- No enable: every clock with rst_n=1 shifts.
- Latency: a bit sampled at edge n appears on serial_out after edge n+DEPTH-1, i.e. DEPTH edges including the sampling edge. For DEPTH=8, the 8th edge after sampling presents it.
- Bit order preserved (FIFO order); no inversion.
- Reset release:
  - Deassertion is asynchronous; the first shift happens on the first rising edge with rst_n=1.
  - Release coincident with an edge: that edge does not shift. Benches keep release ≥1 ns away from posedge.
- Reset mid-stream: assertion at any time discards all in-flight bits. After release, serial_out=0 for the first DEPTH-1 edges, then new data emerges.
- After power-up without reset, contents are undefined (X in simulation). Reset is required before use.
- Continuous stream: throughput 1 bit/clock, no bubbles, no overflow condition.

Decomposition:
- Shared package siso_pkg: localparam SISO_DEFAULT_DEPTH=8 only; no typedefs needed.
- One natural sub-module: siso_stage, a single D flop with async active-low clear. Ports: clk, rst_n, d, q.
- siso_8_bit instantiates DEPTH siso_stage cells in a generate loop, chaining q to d, with serial_out = last q.
- Include elaboration-time check: DEPTH < 2 or > 64 is an error.

Test Plan:
- Async reset: preload all 1s, assert rst_n=0 between clock edges. Required: serial_out=0 within the same timestep, before any clk edge. Hold 3 cycles and drive serial_in=1; serial_out stays 0.
- Pattern delay: release reset, drive 1,0,1,1,1,1,0,1 on 8 consecutive edges then 0s. Required: serial_out=0 for the first 7 edges, then 1,0,1,1,1,1,0,1 after edges 8..15, then 0.
- Reset-held stimulus: keep rst_n=0 while driving the same 8-bit pattern for 18 cycles. Required: serial_out=0 throughout.
- Mid-stream reset: stream all 1s for 5 cycles, pulse rst_n low for 3 ns between edges, then drive 0s. Required: serial_out=0 immediately and never shows the old 1s.
- Single-bit impulse: after reset drive 1 for one cycle, then 0. Required: serial_out=1 for exactly one cycle, after the 8th edge from sampling.
- Parameter sweep DEPTH=2 and DEPTH=16, impulse test. Required: pulse emerges after edge 2 and edge 16 respectively.

Source files
------------

// File: rtl/siso_pkg.sv
// Purpose: shared constants for the serial-in serial-out delay line.
// Latency: n/a (constants only).
// Backpressure: n/a; no flow control anywhere in this block family.
package siso_pkg;

  // Default number of stages, i.e. the default delay in clock cycles.
  localparam int SISO_DEFAULT_DEPTH = 8;

endpackage : siso_pkg

// File: rtl/siso_stage.sv
// Purpose: one delay-line cell, a single D flop with asynchronous clear.
// Latency: 1 clk from d to q.
// Backpressure: none; captures d on every rising clk while out of reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear, forces q to 0
//   d     - data in
//   q     - registered data out
module siso_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule : siso_stage

// File: rtl/siso_8_bit.sv
// Purpose: fixed serial delay line; every bit on serial_in reappears unchanged on serial_out.
// Latency: DEPTH clk edges, counting the edge that samples serial_in.
// Backpressure: none; shifts one bit on every clock, 1 bit/clk sustained, no bubbles.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset, clears every stage immediately
//   serial_in  - serial data bit, sampled on each rising clk edge out of reset
//   serial_out - last stage of the chain, straight from a flop
module siso_8_bit
  import siso_pkg::*;
#(
  parameter int DEPTH = SISO_DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  output logic serial_out
);

  // Reject builds outside the supported delay range at elaboration.
  if (DEPTH < 2 || DEPTH > 64) begin : g_depth_check
    $error("siso_8_bit: DEPTH=%0d outside legal range 2..64", DEPTH);
  end

  // chain[0] is the input tap; chain[i+1] is the output of stage i.
  // Carrying the input as chain[0] keeps the generate body uniform and
  // avoids an out-of-range index on the first stage.
  logic [DEPTH:0] chain;

  assign chain[0] = serial_in;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    siso_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (chain[i]),
      .q     (chain[i+1])
    );
  end

  assign serial_out = chain[DEPTH];

endmodule : siso_8_bit

// File: tb/tb_siso_8_bit.sv
module tb_siso_8_bit;

  logic clk;
  logic rst_n;
  logic serial_in;
  logic out8;
  logic out2;
  logic out16;

  int vectors;
  int miscompares;

  // Reference model: every bit accepted since the last reset, oldest first.
  // The output of a depth-d line is the bit accepted d edges ago, or 0 if
  // fewer than d bits have been accepted since reset.
  bit hist[$];

  siso_8_bit u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .serial_out (out8)
  );

  siso_8_bit #(.DEPTH(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .serial_out (out2)
  );

  siso_8_bit #(.DEPTH(16)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .serial_out (out16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic exp_out(input int d);
    if (hist.size() < d) return 1'b0;
    return hist[hist.size() - d];
  endfunction

  // Drive one bit, clock once, update the model, return 1 ns after the edge.
  task automatic clk_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    if (rst_n === 1'b1) hist.push_back(b);
    #1;
  endtask

  // Short reset pulse placed well away from the clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    hist.delete();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Power-on reset state, no clock edge yet.
    rst_n = 1'b0;
    serial_in = 1'b0;
    #1;
    vectors++;
    if (out8 !== 1'b0 || out2 !== 1'b0 || out16 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out8=%b out2=%b out16=%b required 0 0 0", out8, out2, out16);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    // Preload every stage with 1s.
    for (int k = 0; k < 20; k++) begin
      clk_bit(1'b1);
      vectors++;
      if (out8 !== exp_out(8) || out2 !== exp_out(2) || out16 !== exp_out(16)) begin
        miscompares++;
        $display("FAIL preload edge %0d: got %b%b%b required %b%b%b", k, out8, out2, out16,
                 exp_out(8), exp_out(2), exp_out(16));
      end
    end
    // Asynchronous assert between edges: must clear without a clock.
    #2;
    rst_n = 1'b0;
    hist.delete();
    #1;
    vectors++;
    if (out8 !== 1'b0 || out2 !== 1'b0 || out16 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clear: got %b%b%b required 000", out8, out2, out16);
    end
    // Held in reset with serial_in=1: nothing may shift.
    for (int k = 0; k < 3; k++) begin
      clk_bit(1'b1);
      vectors++;
      if (out8 !== 1'b0 || out2 !== 1'b0 || out16 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %b%b%b required 000", k, out8, out2, out16);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    logic       exp8;
    pat = 8'b1011_1101;  // driven MSB first: 1,0,1,1,1,1,0,1
    pulse_reset();
    for (int k = 1; k <= 24; k++) begin
      clk_bit(k <= 8 ? pat[8-k] : 1'b0);
      // Edge k presents the bit sampled at edge k-7 on the DEPTH=8 line.
      exp8 = (k >= 8 && k <= 15) ? pat[15-k] : 1'b0;
      vectors++;
      if (out8 !== exp8 || out8 !== exp_out(8) || out2 !== exp_out(2) || out16 !== exp_out(16)) begin
        miscompares++;
        $display("FAIL pattern edge %0d: got %b%b%b required %b%b%b", k, out8, out2, out16,
                 exp8, exp_out(2), exp_out(16));
      end
    end
  endtask

  task automatic test_reset_held_stimulus();
    logic [7:0] pat;
    pat = 8'b1011_1101;
    rst_n = 1'b0;
    hist.delete();
    for (int k = 0; k < 18; k++) begin
      clk_bit(pat[7 - (k % 8)]);
      vectors++;
      if (out8 !== 1'b0 || out2 !== 1'b0 || out16 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held cycle %0d: got %b%b%b required 000", k, out8, out2, out16);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_midstream_reset();
    pulse_reset();
    for (int k = 0; k < 5; k++) clk_bit(1'b1);
    // 3 ns low pulse between edges.
    rst_n = 1'b0;
    hist.delete();
    #1;
    vectors++;
    if (out8 !== 1'b0 || out2 !== 1'b0 || out16 !== 1'b0) begin
      miscompares++;
      $display("FAIL midstream_clear: got %b%b%b required 000", out8, out2, out16);
    end
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clk_bit(1'b0);
      vectors++;
      if (out8 !== 1'b0 || out2 !== 1'b0 || out16 !== 1'b0) begin
        miscompares++;
        $display("FAIL midstream_old_bits edge %0d: got %b%b%b required 000", k, out8, out2, out16);
      end
    end
  endtask

  task automatic test_impulse();
    int first8, first2, first16;
    int cnt8, cnt2, cnt16;
    first8 = 0; first2 = 0; first16 = 0;
    cnt8 = 0; cnt2 = 0; cnt16 = 0;
    pulse_reset();
    for (int k = 1; k <= 24; k++) begin
      clk_bit(k == 1 ? 1'b1 : 1'b0);
      if (out8 === 1'b1) begin cnt8++; if (first8 == 0) first8 = k; end
      if (out2 === 1'b1) begin cnt2++; if (first2 == 0) first2 = k; end
      if (out16 === 1'b1) begin cnt16++; if (first16 == 0) first16 = k; end
    end
    vectors++;
    if (first8 != 8 || cnt8 != 1) begin
      miscompares++;
      $display("FAIL impulse_d8: edge %0d width %0d required edge 8 width 1", first8, cnt8);
    end
    vectors++;
    if (first2 != 2 || cnt2 != 1) begin
      miscompares++;
      $display("FAIL impulse_d2: edge %0d width %0d required edge 2 width 1", first2, cnt2);
    end
    vectors++;
    if (first16 != 16 || cnt16 != 1) begin
      miscompares++;
      $display("FAIL impulse_d16: edge %0d width %0d required edge 16 width 1", first16, cnt16);
    end
  endtask

  task automatic test_random_stream();
    pulse_reset();
    for (int k = 0; k < 400; k++) begin
      // Occasional mid-stream reset to exercise the refill behaviour.
      if ($urandom_range(0, 59) == 0) pulse_reset();
      clk_bit(1'($urandom_range(0, 1)));
      vectors++;
      if (out8 !== exp_out(8) || out2 !== exp_out(2) || out16 !== exp_out(16)) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b%b%b required %b%b%b", k, out8, out2, out16,
                 exp_out(8), exp_out(2), exp_out(16));
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    hist.delete();
    test_reset();
    test_pattern();
    test_reset_held_stimulus();
    test_midstream_reset();
    test_impulse();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_siso_8_bit
